// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
//   Shared definitions for the LCD bus responder: the HD44780 command codes
//   that are decoded, the FSM state encoding and the DDRAM address to shadow
//   RAM index mapping.
// -----------------------------------------------------------------------------
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_HOME       = 8'h02;  // 8'h03 homes as well (bit 0 is don't-care)
   localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
   localparam logic [7:0] CMD_ENTRY      = 8'h04;
   localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      CLEAR = 2'd2
   } lcd_state_t;

   // DDRAM address {line, x, x, column[3:0]} -> shadow index {line, column[3:0]}.
   // Line bit (6) moves down to index bit 4; bits 5:4 of the address are dropped.
   function automatic logic [4:0] ddram_to_idx(input logic [6:0] addr7);
      return 5'(((addr7 >> 2) & 7'h10) | (addr7 & 7'h0F));
   endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// -----------------------------------------------------------------------------
// lcd_bus_sync
//   Brings the asynchronous LCD bus into the clk domain through STAGES flops
//   per bit and detects the falling edge of the enable strobe.
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_en/i_rs/i_rw/i_db   raw bus inputs
//   i_rst                 raw active-low soft reset from the driver
//   o_rs/o_rw/o_db/o_rst  synchronised copies
//   o_fall                one-cycle pulse when the synchronised enable falls
// -----------------------------------------------------------------------------
module lcd_bus_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_rs,
   input  logic             i_rw,
   input  logic [WIDTH-1:0] i_db,
   input  logic             i_rst,
   output logic             o_rs,
   output logic             o_rw,
   output logic [WIDTH-1:0] o_db,
   output logic             o_rst,
   output logic             o_fall
);

   // Bus bit layout: {en, rs, rw, rst, db}
   localparam int BW = WIDTH + 4;
   // Soft reset is held inactive (high) out of reset so it cannot glitch the FSM.
   localparam logic [BW-1:0] RST_VAL = BW'(1) << WIDTH;

   logic [STAGES-1:0][BW-1:0] r_stage;
   logic                      r_en_d;
   logic [BW-1:0]             w_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stage <= {STAGES{RST_VAL}};
         r_en_d  <= 1'b0;
      end else begin
         r_stage <= {r_stage[STAGES-2:0], {i_en, i_rs, i_rw, i_rst, i_db}};
         r_en_d  <= w_sync[BW-1];
      end
   end

   assign w_sync = r_stage[STAGES-1];
   assign o_rs   = w_sync[BW-2];
   assign o_rw   = w_sync[BW-3];
   assign o_rst  = w_sync[WIDTH];
   assign o_db   = w_sync[WIDTH-1:0];
   assign o_fall = r_en_d & ~w_sync[BW-1];

endmodule

// File: rtl/lcd_bus_responder.sv
// -----------------------------------------------------------------------------
// lcd_bus_responder
//   Receiving end of the parallel LCD write bus. Latches each write on the
//   falling edge of lcd_en, decodes the HD44780 commands in use and keeps a
//   32-character shadow display RAM with a cursor.
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_lcd_en/rs/rw/db   LCD bus (write on lcd_en falling edge)
//   i_lcd_rst           active-low soft reset from the driver
//   i_rd_addr           shadow RAM read index {line, column}
//   o_rd_data           shadow RAM contents at i_rd_addr (combinational)
//   o_cursor            current write index
//   o_cmd_valid/code    pulse per accepted command / last accepted command
//   o_data_valid        pulse per accepted data write
//   o_busy              clear sequence or post-write timer running
//   o_overrun           sticky: write arrived while busy and was dropped
//   o_rd_attempt        sticky: strobe arrived with rw=1
// -----------------------------------------------------------------------------
module lcd_bus_responder
   import lcd_pkg::*;
#(
   parameter int          BUSY_CYCLES = 50,
   parameter logic [7:0]  CLEAR_CHAR  = 8'h20,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_lcd_en,
   input  logic       i_lcd_rs,
   input  logic       i_lcd_rw,
   input  logic [7:0] i_lcd_db,
   input  logic       i_lcd_rst,
   input  logic [4:0] i_rd_addr,
   output logic [7:0] o_rd_data,
   output logic [4:0] o_cursor,
   output logic       o_cmd_valid,
   output logic [7:0] o_cmd_code,
   output logic       o_data_valid,
   output logic       o_busy,
   output logic       o_overrun,
   output logic       o_rd_attempt
);

   localparam int            TW         = $clog2(BUSY_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(BUSY_CYCLES - 1);

   logic       w_rs, w_rw, w_rst_sync, w_fall;
   logic [7:0] w_db;
   logic       w_soft_rst, w_busy, w_strobe, w_rd_strobe, w_drop;
   logic       w_accept_cmd, w_accept_data;
   logic       w_is_clear, w_is_home, w_is_entry, w_is_ddram;

   lcd_state_t    r_state, w_state_next;
   logic [TW-1:0] r_timer;
   logic [4:0]    r_clr_idx;
   logic [4:0]    r_cursor;
   logic          r_id;
   logic [7:0]    r_ram [32];
   logic          r_cmd_valid, r_data_valid, r_overrun, r_rd_attempt;
   logic [7:0]    r_cmd_code;

   lcd_bus_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_lcd_en),
      .i_rs    (i_lcd_rs),
      .i_rw    (i_lcd_rw),
      .i_db    (i_lcd_db),
      .i_rst   (i_lcd_rst),
      .o_rs    (w_rs),
      .o_rw    (w_rw),
      .o_db    (w_db),
      .o_rst   (w_rst_sync),
      .o_fall  (w_fall)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // Next state; soft reset wins over anything else in the same cycle
   always_comb begin
      w_state_next = r_state;
      if (w_soft_rst) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:  if (w_accept_cmd && w_is_clear)      w_state_next = CLEAR;
                   else if (w_accept_cmd || w_accept_data) w_state_next = EXEC;
            EXEC:  if (r_timer == '0)                  w_state_next = IDLE;
            CLEAR: if (r_clr_idx == 5'd31)             w_state_next = EXEC;
            default:                                   w_state_next = IDLE;
         endcase
      end
   end

   // Outputs of the FSM and strobe classification. A read strobe is flagged
   // even while busy; any write strobe seen while busy is dropped.
   always_comb begin
      w_busy        = (r_state != IDLE);
      w_soft_rst    = ~w_rst_sync;
      w_strobe      = w_fall & ~w_soft_rst;
      w_rd_strobe   = w_strobe & w_rw;
      w_drop        = w_strobe & ~w_rw & w_busy;
      w_accept_cmd  = w_strobe & ~w_rw & ~w_busy & ~w_rs;
      w_accept_data = w_strobe & ~w_rw & ~w_busy & w_rs;
      w_is_clear    = (w_db == CMD_CLEAR);
      w_is_home     = ((w_db & 8'hFE) == CMD_HOME);
      w_is_entry    = ((w_db & CMD_ENTRY_MASK) == CMD_ENTRY);
      w_is_ddram    = ((w_db & CMD_SET_DDRAM) != 8'h00);
   end

   // Datapath: RAM, cursor, timers and flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) r_ram[i] <= CLEAR_CHAR;
         r_cursor     <= '0;
         r_id         <= 1'b1;
         r_timer      <= '0;
         r_clr_idx    <= '0;
         r_cmd_valid  <= 1'b0;
         r_cmd_code   <= '0;
         r_data_valid <= 1'b0;
         r_overrun    <= 1'b0;
         r_rd_attempt <= 1'b0;
      end else begin
         r_cmd_valid  <= 1'b0;
         r_data_valid <= 1'b0;
         if (w_soft_rst) begin
            // RAM, sticky flags and cmd_code survive a soft reset
            r_cursor  <= '0;
            r_id      <= 1'b1;
            r_timer   <= '0;
            r_clr_idx <= '0;
         end else begin
            if (w_rd_strobe) r_rd_attempt <= 1'b1;
            if (w_drop)      r_overrun    <= 1'b1;

            case (r_state)
               EXEC: if (r_timer != '0) r_timer <= r_timer - 1'b1;
               CLEAR: begin
                  r_ram[r_clr_idx] <= CLEAR_CHAR;
                  r_clr_idx        <= r_clr_idx + 5'd1;
                  if (r_clr_idx == 5'd31) r_timer <= TIMER_LOAD;
               end
               default: ;
            endcase

            if (w_accept_cmd) begin
               r_cmd_valid <= 1'b1;
               r_cmd_code  <= w_db;
               if (w_is_clear) begin
                  r_cursor  <= '0;
                  r_clr_idx <= '0;
               end else begin
                  r_timer <= TIMER_LOAD;
                  if (w_is_home)  r_cursor <= '0;
                  if (w_is_entry) r_id     <= w_db[1];
                  if (w_is_ddram) r_cursor <= ddram_to_idx(w_db[6:0]);
               end
            end

            if (w_accept_data) begin
               r_ram[r_cursor] <= w_db;
               r_data_valid    <= 1'b1;
               r_cursor        <= r_id ? r_cursor + 5'd1 : r_cursor - 5'd1;
               r_timer         <= TIMER_LOAD;
            end
         end
      end
   end

   assign o_rd_data    = r_ram[i_rd_addr];
   assign o_cursor     = r_cursor;
   assign o_cmd_valid  = r_cmd_valid;
   assign o_cmd_code   = r_cmd_code;
   assign o_data_valid = r_data_valid;
   assign o_busy       = w_busy;
   assign o_overrun    = r_overrun;
   assign o_rd_attempt = r_rd_attempt;

endmodule
